// File: rtl/tc_mod_accumulator_pkg.sv
// Shared constants and helpers for the thermometer-code residue accumulator.
// Widths are derived from the modulus so every file agrees on them.
package tc_pkg;

   localparam int MOD_MAX = 64;

   function automatic int tc_width(input int mod);
      return mod - 1;
   endfunction

   function automatic int bin_width(input int mod);
      return $clog2(mod);
   endfunction

   // Value k becomes k ones from the LSB, capped at mod-1 ones; callers truncate to tc_width(mod).
   function automatic logic [MOD_MAX-2:0] bin_to_tc(input int value, input int mod);
      logic [MOD_MAX-2:0] tc;
      tc = '0;
      for (int i = 0; i < MOD_MAX - 1; i++) begin
         tc[i] = (i < value) && (i < mod - 1);
      end
      return tc;
   endfunction

endpackage

// File: rtl/tc_mod_accumulator_if.sv
// Streaming handshake bundle for tc_mod_accumulator (input beats, output beats, error status).
// Optional feature macro: TC_MOD_ERR_COUNT_EN adds the err_cnt signal.
interface tc_mod_accumulator_if
   import tc_pkg::*;
#(
   parameter int MOD = 9
);
   localparam int BW  = bin_width(MOD);
   localparam int TCW = tc_width(MOD);

   logic           in_valid;
   logic           in_ready;
   logic [BW-1:0]  in_bin;
   logic           in_clear;
   logic           out_valid;
   logic           out_ready;
   logic [TCW-1:0] out_tc;
   logic [BW-1:0]  out_bin;
   logic           err;
`ifdef TC_MOD_ERR_COUNT_EN
   logic [7:0]     err_cnt;
`endif

   modport master (
      output in_valid, in_bin, in_clear, out_ready,
`ifdef TC_MOD_ERR_COUNT_EN
      input  err_cnt,
`endif
      input  in_ready, out_valid, out_tc, out_bin, err
   );

   modport slave (
      input  in_valid, in_bin, in_clear, out_ready,
`ifdef TC_MOD_ERR_COUNT_EN
      output err_cnt,
`endif
      output in_ready, out_valid, out_tc, out_bin, err
   );

endinterface

// File: rtl/tc_mod_accumulator_bin_to_tc_enc.sv
// Combinational binary-to-thermometer encoder with range check.
// Out-of-range inputs (>= MOD) encode to all zeros.
module bin_to_tc_enc
   import tc_pkg::*;
#(
   parameter  int MOD = 9,
   localparam int BW  = bin_width(MOD),
   localparam int TCW = tc_width(MOD)
) (
   input  logic [BW-1:0]  bin_i,
   output logic [TCW-1:0] tc_o,
   output logic           in_range_o
);

   localparam logic [BW:0] MOD_V = (BW+1)'(MOD);

   assign in_range_o = {1'b0, bin_i} < MOD_V;
   assign tc_o       = in_range_o ? TCW'(bin_to_tc(int'(bin_i), MOD)) : '0;

endmodule

// File: rtl/tc_mod_accumulator.sv
// Two-stage streaming modular accumulator: stage 1 range-checks and encodes, stage 2 accumulates.
// Optional feature macro: TC_MOD_ERR_COUNT_EN adds an 8-bit saturating error counter.
module tc_mod_accumulator
   import tc_pkg::*;
#(
   parameter int MOD = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   tc_mod_accumulator_if.slave  bus
);

   localparam int BW  = bin_width(MOD);
   localparam int TCW = tc_width(MOD);
   localparam logic [BW:0] MOD_V = (BW+1)'(MOD);

   logic           in_ok;
   logic [TCW-1:0] in_tc;
   logic           in_ready;
   logic           in_accept;
   logic           s2_load;

   logic [BW-1:0]  s1_bin_q;
   logic [TCW-1:0] s1_tc_q;
   logic           s1_clear_q;
   logic           s1_valid_q;

   logic [BW-1:0]  acc_q, acc_d;
   logic [TCW-1:0] out_tc_q, out_tc_d;
   logic           out_valid_q;
   logic           err_q;

   logic [BW:0]    sum_raw;
   logic [TCW-1:0] acc_tc;
   logic           acc_in_range_unused;

   bin_to_tc_enc #(.MOD(MOD)) u_in_enc (
      .bin_i      (bus.in_bin),
      .tc_o       (in_tc),
      .in_range_o (in_ok)
   );

   // Stage 1 may refill in the same cycle it hands its beat on, so full throughput has no bubble.
   assign s2_load   = s1_valid_q && (!out_valid_q || bus.out_ready);
   assign in_ready  = !s1_valid_q || s2_load;
   assign in_accept = bus.in_valid && in_ready;

   // Both operands are below MOD, so one conditional subtract brings the sum back into range.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path; a missing default infers a latch.
      sum_raw  = {1'b0, acc_q} + {1'b0, s1_bin_q};
      acc_d    = (sum_raw >= MOD_V) ? BW'(sum_raw - MOD_V) : BW'(sum_raw);
      out_tc_d = acc_tc;
      if (s1_clear_q) begin
         acc_d    = s1_bin_q;
         out_tc_d = s1_tc_q;
      end
   end

   // acc_d is always below MOD, so the range flag of this instance carries no information.
   bin_to_tc_enc #(.MOD(MOD)) u_acc_enc (
      .bin_i      (acc_d),
      .tc_o       (acc_tc),
      .in_range_o (acc_in_range_unused)
   );

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         s1_bin_q    <= '0;
         s1_tc_q     <= '0;
         s1_clear_q  <= 1'b0;
         s1_valid_q  <= 1'b0;
         acc_q       <= '0;
         out_tc_q    <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (in_accept) begin
            s1_bin_q   <= in_ok ? bus.in_bin : '0;
            s1_tc_q    <= in_tc;
            s1_clear_q <= bus.in_clear;
            s1_valid_q <= 1'b1;
         end else if (s2_load) begin
            s1_valid_q <= 1'b0;
         end

         if (s2_load) begin
            acc_q       <= acc_d;
            out_tc_q    <= out_tc_d;
            out_valid_q <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         if (in_accept && !in_ok) begin
            err_q <= 1'b1;
         end
      end
   end

`ifdef TC_MOD_ERR_COUNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (in_accept && !in_ok && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign bus.err_cnt = err_cnt_q;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_tc    = out_tc_q;
   assign bus.out_bin   = acc_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_tc_mod_accumulator.sv
// Self-checking bench: MOD=9 directed table and corner sequences, MOD=5 random stream against a model.
// Optional feature macro: TC_MOD_ERR_COUNT_EN enables the err_cnt check.
module tb_tc_mod_accumulator;
   import tc_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tc_mod_accumulator_if #(.MOD(9)) if9 ();
   tc_mod_accumulator_if #(.MOD(5)) if5 ();

   tc_mod_accumulator #(.MOD(9)) u_dut9 (.clk(clk), .rst(rst), .bus(if9));
   tc_mod_accumulator #(.MOD(5)) u_dut5 (.clk(clk), .rst(rst), .bus(if5));

   typedef struct {
      logic [3:0] bin;
      logic       clear;
      logic [3:0] exp_bin;
      logic [7:0] exp_tc;
      logic       exp_err;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_acc, n_out;
   int   acc_m, e, v;
   logic err_m;
   int   exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [63:0] tc_of(input int val);
      return (64'd1 << val) - 64'd1;
   endfunction

   task automatic idle();
      if9.in_valid = 1'b0; if9.in_bin = '0; if9.in_clear = 1'b0; if9.out_ready = 1'b1;
      if5.in_valid = 1'b0; if5.in_bin = '0; if5.in_clear = 1'b0; if5.out_ready = 1'b1;
   endtask

   initial begin
      // err column is the flag at output time, which already includes the following accepted beat.
      vecs[0] = '{4'd3,  1'b1, 4'd3, 8'b0000_0111, 1'b0};
      vecs[1] = '{4'd4,  1'b0, 4'd7, 8'b0111_1111, 1'b0};
      vecs[2] = '{4'd5,  1'b0, 4'd3, 8'b0000_0111, 1'b0};
      vecs[3] = '{4'd8,  1'b1, 4'd8, 8'b1111_1111, 1'b0};
      vecs[4] = '{4'd1,  1'b0, 4'd0, 8'b0000_0000, 1'b0};
      vecs[5] = '{4'd5,  1'b1, 4'd5, 8'b0001_1111, 1'b1};
      vecs[6] = '{4'd12, 1'b0, 4'd5, 8'b0001_1111, 1'b1};
      vecs[7] = '{4'd2,  1'b0, 4'd7, 8'b0111_1111, 1'b1};
      vecs[8] = '{4'd15, 1'b1, 4'd0, 8'b0000_0000, 1'b1};

      // Reset held for 2 cycles with a beat offered: nothing may be taken.
      idle();
      rst = 1'b1;
      if9.in_valid = 1'b1;
      if9.in_bin   = 4'd7;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", if9.out_valid, 0);
      check("rst_out_tc",    if9.out_tc,    0);
      check("rst_out_bin",   if9.out_bin,   0);
      check("rst_err",       if9.err,       0);
      check("rst_in_ready",  if9.in_ready,  1);
      rst = 1'b0;
      if9.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_no_beat_valid", if9.out_valid, 0);
      check("rst_no_beat_bin",   if9.out_bin,   0);

      // Back-to-back table stream; row k must appear two cycles after it was offered.
      for (int k = 0; k < NV + 2; k++) begin
         if (k >= 2) begin
            check($sformatf("v%0d_valid", k - 2), if9.out_valid, 1);
            check($sformatf("v%0d_bin",   k - 2), if9.out_bin,   vecs[k-2].exp_bin);
            check($sformatf("v%0d_tc",    k - 2), if9.out_tc,    vecs[k-2].exp_tc);
            check($sformatf("v%0d_err",   k - 2), if9.err,       vecs[k-2].exp_err);
         end
         if (k < NV) begin
            if9.in_valid = 1'b1;
            if9.in_bin   = vecs[k].bin;
            if9.in_clear = vecs[k].clear;
            #1 check($sformatf("v%0d_in_ready", k), if9.in_ready, 1);
         end else begin
            if9.in_valid = 1'b0;
            if9.in_clear = 1'b0;
         end
         @(negedge clk);
      end
      check("tbl_drained", if9.out_valid, 0);
      check("tbl_err_sticky", if9.err, 1);
`ifdef TC_MOD_ERR_COUNT_EN
      check("tbl_err_cnt", if9.err_cnt, 2);
`endif

      // Fill both stages under a stall, then reset mid-operation.
      if9.out_ready = 1'b0;
      if9.in_valid  = 1'b1;
      if9.in_bin    = 4'd3;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid", if9.out_valid, 0);
      check("mid_rst_bin",   if9.out_bin,   0);
      check("mid_rst_err",   if9.err,       0);

      // Backpressure: ones offered for 4 stalled cycles; first beat after reset must add to 0.
      if9.in_bin = 4'd1;
      n_acc = 0;
      for (int c = 0; c < 4; c++) begin
         #1 if (if9.in_valid && if9.in_ready) n_acc++;
         @(negedge clk);
      end
      check("bp_accepted",   n_acc,          2);
      check("bp_ready_low",  if9.in_ready,   0);
      check("bp_hold_valid", if9.out_valid,  1);
      check("bp_hold_bin",   if9.out_bin,    1);
      check("bp_hold_tc",    if9.out_tc,     tc_of(1));

      if9.out_ready = 1'b1;
      n_out = 0;
      for (int c = 0; c < 40 && n_out < 6; c++) begin
         if (n_acc >= 6) if9.in_valid = 1'b0;
         #1;
         if (if9.out_valid && if9.out_ready) begin
            n_out++;
            check($sformatf("bp_out%0d_bin", n_out), if9.out_bin, n_out);
            check($sformatf("bp_out%0d_tc",  n_out), if9.out_tc,  tc_of(n_out));
         end
         if (if9.in_valid && if9.in_ready) n_acc++;
         @(negedge clk);
      end
      check("bp_out_count", n_out, 6);
      check("bp_in_count",  n_acc, 6);
      @(negedge clk);
      check("bp_no_dup", if9.out_valid, 0);

      // Random stream on the modulus-5 instance, with random stalls, against a modular-sum model.
      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      acc_m = 0; n_acc = 0; n_out = 0; err_m = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 20000 && (n_acc < 1000 || n_out < n_acc); c++) begin
         if5.in_valid  = (n_acc < 1000) && ($urandom_range(0, 9) < 7);
         if5.in_bin    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                                     : 3'($urandom_range(0, 4));
         if5.in_clear  = ($urandom_range(0, 15) == 0);
         if5.out_ready = ($urandom_range(0, 9) < 7);
         #1;
         if (if5.out_valid && if5.out_ready) begin
            check("rnd_expected_beat", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check($sformatf("rnd%0d_bin", n_out), if5.out_bin, e);
               check($sformatf("rnd%0d_tc",  n_out), if5.out_tc,  tc_of(e));
            end
            n_out++;
         end
         if (if5.in_valid && if5.in_ready) begin
            v = (int'(if5.in_bin) < 5) ? int'(if5.in_bin) : 0;
            if (int'(if5.in_bin) >= 5) err_m = 1'b1;
            acc_m = if5.in_clear ? v : (acc_m + v) % 5;
            exp_q.push_back(acc_m);
            n_acc++;
         end
         @(negedge clk);
      end
      check("rnd_accepted", n_acc, 1000);
      check("rnd_drained",  n_out, n_acc);
      check("rnd_err",      if5.err, err_m);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tc_mod_accumulator.md
Name: tc_mod_accumulator

Overview:
Parametrised streaming residue accumulator for the RNS datapath. It accepts binary residues modulo MOD over a valid/ready handshake and converts each to thermometer code of width MOD-1. It keeps a running modular sum and presents that sum in both thermometer and binary form. It is the generic, pipelined successor of the fixed mod-9 binary-to-thermometer converter and feeds the thermometer-code modulo adders.

Parameters:
MOD, 9, modulus; legal range 3..64; thermometer width TCW = MOD-1.
BW, $clog2(MOD), binary residue width; derived localparam, not overridable.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat present
in_ready  out  1  block can accept an input beat
in_bin  in  BW  binary residue to add
in_clear  in  1  sideband of input beat: load in_bin instead of adding it
out_valid  out  1  output beat present
out_ready  in  1  downstream accepts output beat
out_tc  out  TCW  running sum, thermometer code (LSB-filled; value k -> k low bits set)
out_bin  out  BW  running sum, binary
err  out  1  sticky flag: an out-of-range input was accepted

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). Reset dominates every other event in the same cycle.
- Reset values: in_ready=1 (follows from stage 1 empty), out_valid=0, out_tc=0, out_bin=0, err=0, accumulator=0, stage-1 register empty.
- Two-stage pipeline, latency 2 cycles from input accept to out_valid when not stalled.
- Stage 1 (convert): registers s1_bin, s1_tc, s1_clear and s1_valid.
- Input accept = in_valid && in_ready.
- in_ready = !s1_valid || s2_load. This is a combinational path from out_ready, with no bubble at full throughput.
- Out-of-range input (in_bin >= MOD): treated as value 0 and the thermometer code is all zeros. err is set on accept and stays set until rst.
- Stage 2 (accumulate): s2_load = s1_valid && (!out_valid || out_ready).
- On s2_load: acc = s1_clear ? s1_bin : (acc + s1_bin) mod MOD.
  - The sum is computed at BW+1 bits; if the sum >= MOD, subtract MOD. A single conditional subtract is enough because both operands are < MOD.
- out_bin and out_tc are registered from the new acc. out_valid is set.
- out_valid clears when out_ready && !s2_load. Output registers hold stable while out_valid && !out_ready.
- Maximum throughput is 1 beat/cycle. Under a full stall, at most 2 beats are held (stage 1 + output); none is dropped or duplicated.
- Wrap-around: MOD-1 + 1 gives 0, with out_tc all zeros.
- in_clear with an out-of-range value loads 0 and sets err.
- Reset mid-operation discards both stages and the accumulator. The first beat after reset adds to 0.
- out_tc is always a valid thermometer code (contiguous ones from the LSB). The default/x case of the old converter is eliminated.

Optional Feature:
Macro TC_MOD_ERR_COUNT_EN.
- Defined: adds output port err_cnt [7:0], an 8-bit saturating count of accepted out-of-range beats. It resets to 0 and saturates at 255. err is still provided.
- Undefined: no err_cnt port or logic. Behaviour is otherwise identical.

Decomposition:
- Package tc_pkg holds:
  - function tc_width(mod) returning mod-1;
  - function bin_width(mod) returning $clog2(mod);
  - typedef-free constant MOD_MAX = 64;
  - function bin_to_tc(value, mod) returning a thermometer vector.
- One natural sub-module: bin_to_tc_enc. It is a combinational, parametrised binary-to-thermometer encoder with a range-check output. It is instantiated in stage 1 and again on the accumulator result.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1 -> out_valid=0, out_tc=0, out_bin=0, err=0 and no beat consumed.
- MOD=9, beats {3 with clear, 4, 5} streamed back-to-back, out_ready=1 -> outputs appear 2 cycles after each accept: 3/00000111, 7/01111111, 3/00000111 (12 mod 9).
- MOD=9, beats {8 with clear, 1} -> 8/11111111, then wrap to 0/00000000.
- MOD=9, beat 12 after sum 5 -> err=1, output 5/00011111 (unchanged). err stays 1 through later valid beats until rst; err_cnt=1 when TC_MOD_ERR_COUNT_EN is defined.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 with values 1,1,1,... -> exactly 2 beats accepted and in_ready=0 afterwards. On release, outputs are 1,2,3,... in order with no loss or duplication.
- MOD=5 build, random stream of 1000 beats with random stalls, compared against a reference model of the modular sum -> out_bin matches and out_tc equals the thermometer code of out_bin every accepted beat.
